// File: rtl/fifo_pkg.sv
// Shared FIFO read-side defaults: widths, pointer width helper
// and the output-credit limit.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Words the read side may hold: buffered plus in flight.
  localparam int CREDIT_MAX = 2;

  // Read pointer carries one extra wrap bit.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: push lands RAM data, pop on valid & ready.
// Ports: push/push_data in, rready in, rdata/rvalid/pop out.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              pop
);

  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;
  logic              v0;
  logic              v1;

  assign pop    = v0 & rready;
  assign rdata  = slot0;
  assign rvalid = v0;

  always_ff @(posedge i_clk) begin
    if (!i_rest) begin
      slot0 <= '0;
      slot1 <= '0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          // Arriving word takes the freed place; no bubble.
          if (v1) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        pop && !push: begin
          slot0 <= slot1;
          v0    <= v1;
          v1    <= 1'b0;
        end
        push && !pop: begin
          if (!v0) begin
            slot0 <= push_data;
            v0    <= 1'b1;
          end else begin
            slot1 <= push_data;
            v1    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_control.sv
// FIFO read-side controller: gates reads on empty, owns rd_ptr,
// drives the RAM read port and a valid/ready output via fifo_rd_skid.
module fifo_read_control
  import fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              i_ren,
  input  logic              i_empty,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,
  output logic              o_ren_ctrl,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W:0]   o_rd_ptr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_underflow
);

  localparam int PTR_W = ptr_w(ADDR_W);

  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       cnt;
  logic             in_flight;
  logic             underflow;
  logic             pop;
  logic             req;
  logic             issue;

  // Credit covers buffered and in-flight words, so the buffer
  // can never be pushed while full.
  assign req   = i_rest & i_ren &
                 ((cnt < 2'(CREDIT_MAX)) | pop);
  assign issue = req & ~i_empty;

  assign o_ren_ctrl  = issue;
  assign o_raddr     = rd_ptr[ADDR_W-1:0];
  assign o_rd_ptr    = rd_ptr;
  assign o_underflow = underflow;

  always_ff @(posedge i_clk) begin
    if (!i_rest) begin
      rd_ptr    <= '0;
      cnt       <= '0;
      in_flight <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      in_flight <= issue;
      unique case ({issue, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: ;
      endcase
      // Checker hook: a read launched against an empty FIFO.
      if (issue & i_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk     (i_clk),
    .i_rest    (i_rest),
    .push      (in_flight),
    .push_data (i_rdata),
    .rready    (i_rready),
    .rdata     (o_rdata),
    .rvalid    (o_rvalid),
    .pop       (pop)
  );

endmodule

// File: tb/tb_fifo_read_control.sv
// Bench for fifo_read_control: RAM model, queue-based reference
// model of delivered words, directed phases plus random traffic.
module tb_fifo_read_control;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_rest;
  logic          i_ren;
  logic          i_empty;
  logic [DW-1:0] i_rdata;
  logic          i_rready;
  logic          o_ren_ctrl;
  logic [AW-1:0] o_raddr;
  logic [AW:0]   o_rd_ptr;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_underflow;

  fifo_read_control #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .i_clk       (i_clk),
    .i_rest      (i_rest),
    .i_ren       (i_ren),
    .i_empty     (i_empty),
    .i_rdata     (i_rdata),
    .i_rready    (i_rready),
    .o_ren_ctrl  (o_ren_ctrl),
    .o_raddr     (o_raddr),
    .o_rd_ptr    (o_rd_ptr),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous RAM, one-cycle read latency.
  logic [DW-1:0] mem [16];
  always @(posedge i_clk)
    if (o_ren_ctrl) i_rdata <= mem[o_raddr];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words issued, landed, consumed.
  int            avail;
  int            issued;
  int            popped;
  int            landed;
  bit            prev_issue;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cycle_step();
    bit exp_v;
    bit exp_pop;
    bit exp_iss;
    int held;
    i_empty = (avail == 0);
    #1;
    if (!i_rest) begin
      chk("rst_ren", 32'(o_ren_ctrl), 32'd0);
      @(posedge i_clk);
      issued     = 0;
      popped     = 0;
      landed     = 0;
      prev_issue = 0;
      exp_q.delete();
    end else begin
      exp_v   = (landed - popped) > 0;
      exp_pop = exp_v && i_rready;
      held    = issued - popped;
      exp_iss = i_ren && (avail > 0) &&
                ((held - int'(exp_pop)) < 2);
      chk("rvalid", 32'(o_rvalid), 32'(exp_v));
      if (exp_pop && exp_q.size() > 0)
        chk("rdata", 32'(o_rdata), 32'(exp_q[0]));
      chk("ren_ctrl", 32'(o_ren_ctrl), 32'(exp_iss));
      chk("rd_ptr", 32'(o_rd_ptr), 32'(issued % 32));
      chk("raddr", 32'(o_raddr), 32'(issued % 16));
      chk("underflow", 32'(o_underflow), 32'd0);
      @(posedge i_clk);
      if (exp_pop) begin
        void'(exp_q.pop_front());
        popped++;
      end
      landed += int'(prev_issue);
      prev_issue = exp_iss;
      if (exp_iss) begin
        exp_q.push_back(mem[issued % 16]);
        issued++;
        avail--;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset(input int n);
    i_rest = 1'b0;
    repeat (n) cycle_step();
    i_rest = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    i_rest   = 1'b0;
    i_ren    = 1'b1;
    i_rready = 1'b0;
    i_empty  = 1'b0;
    avail    = 5;
    issued   = 0;
    popped   = 0;
    landed   = 0;
    prev_issue = 0;
    fill_random();
    @(negedge i_clk);

    // Reset held with a request pending.
    repeat (2) cycle_step();
    i_rest = 1'b1;
    i_ren  = 1'b0;
    chk("rst_rvalid", 32'(o_rvalid), 32'd0);
    chk("rst_ptr", 32'(o_rd_ptr), 32'd0);
    chk("rst_uf", 32'(o_underflow), 32'd0);
    cycle_step();

    // Stream of three words.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    avail    = 3;
    i_ren    = 1'b1;
    i_rready = 1'b1;
    repeat (8) cycle_step();
    chk("stream_ptr", 32'(o_rd_ptr), 32'd3);

    // Backpressure: only two words fetched.
    do_reset(1);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    mem[3] = 8'h44; mem[4] = 8'h55;
    avail    = 5;
    i_rready = 1'b0;
    repeat (6) cycle_step();
    chk("bp_ptr", 32'(o_rd_ptr), 32'd2);
    chk("bp_valid", 32'(o_rvalid), 32'd1);
    chk("bp_head", 32'(o_rdata), 32'h11);
    i_rready = 1'b1;
    repeat (10) cycle_step();
    chk("bp_drain_ptr", 32'(o_rd_ptr), 32'd5);
    chk("bp_drain_valid", 32'(o_rvalid), 32'd0);

    // Empty gating.
    avail = 0;
    repeat (10) cycle_step();
    chk("empty_ptr", 32'(o_rd_ptr), 32'd5);
    chk("empty_uf", 32'(o_underflow), 32'd0);

    // Pointer wrap over 20 reads.
    do_reset(1);
    fill_random();
    avail = 20;
    repeat (26) cycle_step();
    chk("wrap_ptr", 32'(o_rd_ptr), 32'd20);
    chk("wrap_raddr", 32'(o_raddr), 32'd4);

    // Reset with two credits used and a word in flight.
    do_reset(1);
    fill_random();
    avail    = 10;
    i_rready = 1'b0;
    repeat (2) cycle_step();
    i_rest = 1'b0;
    cycle_step();
    i_rest = 1'b1;
    i_ren  = 1'b0;
    chk("mid_rvalid", 32'(o_rvalid), 32'd0);
    chk("mid_ptr", 32'(o_rd_ptr), 32'd0);
    i_ren    = 1'b1;
    i_rready = 1'b1;
    repeat (6) cycle_step();

    // Random traffic with occasional resets.
    do_reset(1);
    fill_random();
    avail = 0;
    repeat (400) begin
      i_ren    = ($urandom_range(0, 3) != 0);
      i_rready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0 && avail < 16) avail++;
      i_rest   = ($urandom_range(0, 60) != 0);
      cycle_step();
    end
    i_rest = 1'b1;
    i_ren  = 1'b0;
    repeat (4) cycle_step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_control.md
Name: fifo_read_control

Overview:
- Read-side controller for the single-clock FIFO; the counterpart of the write-side gating block.
- Gates the read request against the empty flag and owns the read pointer.
- Drives the synchronous RAM read port (1-cycle read latency) and presents data to the consumer over a valid/ready interface.
- A 2-entry output buffer absorbs RAM latency, so back-to-back reads sustain 1 word/cycle under continuous ready.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, data word width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rest  in  1  reset; synchronous, active-low (0 = reset).
- i_ren  in  1  read enable from consumer side; 1 = controller may fetch words.
- i_empty  in  1  FIFO empty flag from status logic.
- i_rdata  in  DATA_W  RAM read data, valid 1 cycle after o_ren_ctrl.
- i_rready  in  1  consumer ready.
- o_ren_ctrl  out  1  qualified RAM read enable.
- o_raddr  out  ADDR_W  RAM read address = rd_ptr[ADDR_W-1:0].
- o_rd_ptr  out  ADDR_W+1  read pointer incl. wrap bit, to status logic.
- o_rdata  out  DATA_W  output data (head of buffer).
- o_rvalid  out  1  o_rdata valid.
- o_underflow  out  1  sticky error flag.

Behaviour:
- Reset (i_rest=0 at edge): rd_ptr=0, credit cnt=0, buffer empty, in-flight flag=0, o_rvalid=0, o_rdata=0, o_underflow=0. o_ren_ctrl=0 combinationally while i_rest=0.
- pop = o_rvalid & i_rready.
- issue = i_rest & i_ren & ~i_empty & (cnt<2 | pop). o_ren_ctrl = issue (combinational).
- On issue: rd_ptr <= rd_ptr+1 (modulo 2**(ADDR_W+1); wrap bit toggles when low bits pass 2**ADDR_W-1); in-flight flag set for next cycle.
- Cycle after issue: i_rdata is written into the buffer (slot 0 if empty or popping its only entry, else slot 1).
- Credit counter: cnt <= cnt + issue - pop; range 0..2 (holds buffered + in-flight words). Issue never makes cnt exceed 2.
- Latency: issue in cycle N gives o_rvalid=1 with that data in cycle N+1 when the buffer was empty (data written through to o_rdata).
  - Implementation choice: o_rdata is registered, so o_rvalid/o_rdata appear at cycle N+2 relative to the issue edge.
  - Fixed rule: first word appears 2 edges after o_ren_ctrl is sampled high.
- Ordering: strict FIFO order; the skid slot shifts to head on pop.
- Simultaneous issue+pop with cnt=2: allowed; cnt stays 2.
- Pop with buffer holding 1 word and an in-flight word arriving: arriving word becomes head the same edge; no bubble.
- i_ren=0: no new issue; in-flight word still lands, buffered words still drain.
- i_empty rising while a word is in flight: the in-flight word is still delivered.
- Underflow: o_underflow <= 1 if the RAM enable would assert with i_empty=1. Unreachable by design; serves as a checker hook and is cleared only by reset.
- Reset mid-operation: buffer, in-flight word and pointer are discarded immediately; outputs at reset values the next cycle.

Decomposition:
- Shared package (fifo_pkg): ADDR_W/DATA_W defaults, pointer width function (ADDR_W+1), credit max constant 2.
- One sub-module: fifo_rd_skid, a 2-entry valid/ready output buffer with push/pop and data/valid out.
- The parent holds pointer, credit counter, issue logic and underflow flag.

Test Plan:
- Reset: i_rest=0 for 2 cycles with i_ren=1, i_empty=0 → o_ren_ctrl=0, o_rvalid=0, o_rd_ptr=0, o_underflow=0.
- Stream: FIFO holds 0x11,0x22,0x33; i_ren=1, i_rready=1 → o_ren_ctrl high 3 consecutive cycles; o_rdata 0x11,0x22,0x33 on consecutive cycles starting 2 edges after first issue; o_rd_ptr ends at 3.
- Backpressure: 5 words, i_rready=0 → exactly 2 issues, then o_ren_ctrl=0, o_rvalid=1 holding 0x11. Release i_rready → remaining words delivered in order, no loss or duplicate.
- Empty gating: i_empty=1, i_ren=1 for 10 cycles → o_ren_ctrl=0, o_rd_ptr unchanged, o_underflow=0.
- Wrap: ADDR_W=4, 20 reads → o_raddr sequence 0..15,0..3; o_rd_ptr=20 (wrap bit 1, low bits 4).
- Mid-op reset: reset asserted while cnt=2 and a word is in flight → next cycle o_rvalid=0, o_rd_ptr=0; post-reset reads restart from address 0.
